// File: rtl/mod_n_ctrl_pkg.sv
// Shared types and helpers for the mod-N counter arbiter.
package mod_n_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PULSE      = 3'd1,
        SETTLE     = 3'd2,
        CHECK      = 3'd3,
        CLEAR      = 3'd4,
        CLR_SETTLE = 3'd5
    } state_e;

    // Width of the settle down-counter. It only ever holds cycles-1, and it
    // keeps at least one bit so the declaration stays legal when cycles is 1.
    function automatic int settle_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    int idx;

    // Walk the requesters starting at ptr and grant the first active one.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!valid && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_n_counter_arbiter.sv
// Shares one ripple mod-N counter between several requesters. The block issues
// single-cycle incr/clear strobes, then waits for the ripple chain to settle
// and compares the readback against a shadow count.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no strobe in flight; arbitrate clear/increment requests
// PULSE      | incr_o and the one-hot grant are high; shadow advances
// SETTLE     | strobes low while the ripple chain settles after an incr
// CHECK      | compare count_i with the shadow, then arbitrate like IDLE
// CLEAR      | clear_o/clear_ack_o are high; shadow and mismatch reset
// CLR_SETTLE | strobes low while the chain settles after a clear
//
// Outputs are registered and decoded from the next state, so each strobe
// lines up exactly with the cycle in which the FSM sits in that state.
module mod_n_counter_arbiter
    import mod_n_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MOD_N         = 5,
    parameter int CNT_W         = $clog2(MOD_N),
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               clear_req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               clear_ack_o,
    output logic               incr_o,
    output logic               clear_o,
    input  logic [CNT_W-1:0]   count_i,
    output logic [CNT_W-1:0]   shadow_o,
    output logic               wrap_o,
    output logic               busy_o,
    output logic               mismatch_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SET_W = settle_cnt_w(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHADOW_MAX  = CNT_W'(MOD_N - 1);

    state_e               state_q;
    state_e               state_d;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_nx;
    logic [SET_W-1:0]     settle_q;
    logic                 clr_pend_q;
    logic                 clr_any;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic                 arb_valid;
    logic [NUM_REQ-1:0]   gnt_d;
    logic                 wrap_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // A clear request seen in the decision cycle itself counts as pending.
    assign clr_any = clr_pend_q | clear_req_i;

    // State register; reset parks in CLEAR so the counter is forced to 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= CLEAR;
        else         state_q <= state_d;
    end

    // Next-state decode; clear beats increment at every decision point.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CHECK: begin
                if (clr_any)        state_d = CLEAR;
                else if (arb_valid) state_d = PULSE;
                else                state_d = IDLE;
            end
            PULSE:      state_d = SETTLE;
            SETTLE:     if (settle_q == '0) state_d = CHECK;
            CLEAR:      state_d = CLR_SETTLE;
            CLR_SETTLE: if (settle_q == '0) state_d = CHECK;
            default:    state_d = IDLE;
        endcase
    end

    // Output decode for the cycle about to start: grant, wrap and next pointer.
    always_comb begin
        gnt_d  = '0;
        wrap_d = 1'b0;
        ptr_nx = ptr_q;
        if (state_d == PULSE) begin
            gnt_d  = arb_gnt;
            wrap_d = (shadow_o == SHADOW_MAX);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (arb_gnt[i]) ptr_nx = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Arbitration pointer, settle down-counter and merged clear-pending flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            settle_q   <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            ptr_q <= ptr_nx;
            if (state_q == PULSE || state_q == CLEAR) settle_q <= SETTLE_LOAD;
            else if (settle_q != '0)                   settle_q <= settle_q - SET_W'(1);
            if (state_q == CLEAR)  clr_pend_q <= clear_req_i;
            else if (clear_req_i)  clr_pend_q <= 1'b1;
        end
    end

    // Registered strobes, shadow count and sticky mismatch flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_o       <= '0;
            incr_o      <= 1'b0;
            clear_o     <= 1'b1;
            clear_ack_o <= 1'b0;
            wrap_o      <= 1'b0;
            busy_o      <= 1'b1;
            shadow_o    <= '0;
            mismatch_o  <= 1'b0;
        end else begin
            gnt_o       <= gnt_d;
            incr_o      <= (state_d == PULSE);
            clear_o     <= (state_d == CLEAR);
            clear_ack_o <= (state_d == CLEAR);
            wrap_o      <= wrap_d;
            busy_o      <= (state_d != IDLE);
            if (state_q == PULSE)
                shadow_o <= (shadow_o == SHADOW_MAX) ? '0 : shadow_o + CNT_W'(1);
            else if (state_q == CLEAR)
                shadow_o <= '0;
            if (state_q == CLEAR)
                mismatch_o <= 1'b0;
            else if (state_q == CHECK && count_i != shadow_o)
                mismatch_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_n_counter_arbiter.sv
// Directed bench for mod_n_counter_arbiter with a behavioural ripple counter
// whose readback lags the strobes by one cycle.
module tb_mod_n_counter_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       clear_req;
    logic [3:0] gnt;
    logic       clear_ack;
    logic       incr;
    logic       clear;
    logic [2:0] count;
    logic [2:0] shadow;
    logic       wrap;
    logic       busy;
    logic       mismatch;

    logic [2:0] cnt_raw = '0;
    logic       drop_en;

    int n_cmp = 0;
    int n_bad = 0;

    mod_n_counter_arbiter #(
        .NUM_REQ       (4),
        .MOD_N         (5),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .clear_req_i (clear_req),
        .gnt_o       (gnt),
        .clear_ack_o (clear_ack),
        .incr_o      (incr),
        .clear_o     (clear),
        .count_i     (count),
        .shadow_o    (shadow),
        .wrap_o      (wrap),
        .busy_o      (busy),
        .mismatch_o  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: drop_en lets the bench swallow an increment.
    always @(posedge clk) begin
        if (clear)                 cnt_raw <= 3'd0;
        else if (incr && !drop_en) cnt_raw <= (cnt_raw == 3'd4) ? 3'd0 : cnt_raw + 3'd1;
        count <= cnt_raw;
    end

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (gnt !== 4'b0000) break;
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b0) break;
        end
    endtask

    task automatic test_reset;
        int cyc;
        rst_n = 1'b0; req = '0; clear_req = 1'b0; drop_en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (clear !== 1'b1)   begin n_bad++; $display("FAIL rst_clear got %b want 1", clear); end
        n_cmp++; if (incr !== 1'b0)    begin n_bad++; $display("FAIL rst_incr got %b want 0", incr); end
        n_cmp++; if (gnt !== 4'b0000)  begin n_bad++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        n_cmp++; if (wrap !== 1'b0)    begin n_bad++; $display("FAIL rst_wrap got %b want 0", wrap); end
        n_cmp++; if (shadow !== 3'd0)  begin n_bad++; $display("FAIL rst_shadow got %0d want 0", shadow); end
        n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL rst_mismatch got %b want 0", mismatch); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (clear !== 1'b0)   begin n_bad++; $display("FAIL rst_clear_single got %b want 0", clear); end
        n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL rst_busy got %b want 1", busy); end
        wait_idle(cyc);
        n_cmp++; if (cyc !== 3)        begin n_bad++; $display("FAIL rst_idle_latency got %0d want 3", cyc); end
        n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL rst_check got %b want 0", mismatch); end
    endtask

    task automatic test_wrap;
        int cyc;
        logic [2:0] exp_sh;
        logic exp_wr;
        req = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            wait_gnt(cyc);
            exp_sh = 3'(k - 1);
            exp_wr = (k == 5);
            n_cmp++; if (cyc !== ((k == 1) ? 1 : 4)) begin n_bad++; $display("FAIL wrap_spacing k=%0d got %0d", k, cyc); end
            n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt k=%0d got %b want 0001", k, gnt); end
            n_cmp++; if (incr !== 1'b1 || clear !== 1'b0) begin n_bad++; $display("FAIL wrap_strobes k=%0d incr %b clear %b want 1 0", k, incr, clear); end
            n_cmp++; if (wrap !== exp_wr) begin n_bad++; $display("FAIL wrap_flag k=%0d got %b want %b", k, wrap, exp_wr); end
            n_cmp++; if (shadow !== exp_sh) begin n_bad++; $display("FAIL wrap_shadow k=%0d got %0d want %0d", k, shadow, exp_sh); end
        end
        @(negedge clk);
        req = 4'b0000;
        n_cmp++; if (shadow !== 3'd0 || wrap !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL wrap_after shadow %0d wrap %b gnt %b want 0 0 0000", shadow, wrap, gnt); end
        wait_idle(cyc);
        n_cmp++; if (busy !== 1'b0 || mismatch !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL wrap_idle busy %b mismatch %b count %0d want 0 0 0", busy, mismatch, count); end
    endtask

    task automatic test_round_robin;
        int cyc;
        logic [3:0] exp_rr [6] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
        req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(cyc);
            n_cmp++; if (gnt !== exp_rr[k]) begin n_bad++; $display("FAIL rr_gnt k=%0d got %b want %b", k, gnt, exp_rr[k]); end
            n_cmp++; if (cyc !== ((k == 0) ? 1 : 4)) begin n_bad++; $display("FAIL rr_spacing k=%0d got %0d", k, cyc); end
        end
        @(negedge clk);
        req = 4'b0000;
        wait_idle(cyc);
        n_cmp++; if (shadow !== 3'd1 || mismatch !== 1'b0) begin n_bad++; $display("FAIL rr_end shadow %0d mismatch %b want 1 0", shadow, mismatch); end
    endtask

    task automatic test_clear_priority;
        int cyc;
        req = 4'b0001;
        wait_gnt(cyc);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL prio_gnt got %b want 0001", gnt); end
        @(negedge clk);
        n_cmp++; if (shadow !== 3'd2) begin n_bad++; $display("FAIL prio_shadow got %0d want 2", shadow); end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (incr !== 1'b0 || clear !== 1'b0) begin n_bad++; $display("FAIL prio_check incr %b clear %b want 0 0", incr, clear); end
        @(negedge clk);
        n_cmp++; if (clear !== 1'b1 || clear_ack !== 1'b1 || incr !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL prio_clear clear %b ack %b incr %b gnt %b want 1 1 0 0000", clear, clear_ack, incr, gnt); end
        @(negedge clk);
        n_cmp++; if (shadow !== 3'd0 || clear !== 1'b0 || clear_ack !== 1'b0) begin n_bad++; $display("FAIL prio_after shadow %0d clear %b ack %b want 0 0 0", shadow, clear, clear_ack); end
        wait_gnt(cyc);
        n_cmp++; if (cyc !== 3 || gnt !== 4'b0001) begin n_bad++; $display("FAIL prio_regrant cyc %0d gnt %b want 3 0001", cyc, gnt); end
        @(negedge clk);
        req = 4'b0000;
        wait_idle(cyc);
        n_cmp++; if (shadow !== 3'd1 || count !== 3'd1 || mismatch !== 1'b0) begin n_bad++; $display("FAIL prio_end shadow %0d count %0d mismatch %b want 1 1 0", shadow, count, mismatch); end
    endtask

    task automatic test_fault;
        int cyc;
        drop_en = 1'b1;
        req = 4'b0001;
        wait_gnt(cyc);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL fault_gnt got %b want 0001", gnt); end
        @(negedge clk);
        req = 4'b0000; drop_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL fault_early got %b want 0", mismatch); end
        @(negedge clk);
        n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL fault_detect got %b want 1", mismatch); end
        req = 4'b0001;
        wait_gnt(cyc);
        @(negedge clk);
        req = 4'b0000;
        wait_idle(cyc);
        n_cmp++; if (mismatch !== 1'b1 || shadow !== 3'd3 || count !== 3'd2) begin n_bad++; $display("FAIL fault_sticky mismatch %b shadow %0d count %0d want 1 3 2", mismatch, shadow, count); end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        n_cmp++; if (clear !== 1'b1 || clear_ack !== 1'b1) begin n_bad++; $display("FAIL fault_clear clear %b ack %b want 1 1", clear, clear_ack); end
        @(negedge clk);
        n_cmp++; if (mismatch !== 1'b0 || shadow !== 3'd0) begin n_bad++; $display("FAIL fault_cleared mismatch %b shadow %0d want 0 0", mismatch, shadow); end
        wait_idle(cyc);
        n_cmp++; if (mismatch !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL fault_end mismatch %b count %0d busy %b want 0 0 0", mismatch, count, busy); end
    endtask

    task automatic test_mid_reset;
        int cyc;
        req = 4'b0001;
        wait_gnt(cyc);
        n_cmp++; if (incr !== 1'b1) begin n_bad++; $display("FAIL midrst_pulse incr got %b want 1", incr); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (incr !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL midrst_abort incr %b gnt %b want 0 0000", incr, gnt); end
        n_cmp++; if (clear !== 1'b1 || shadow !== 3'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL midrst_state clear %b shadow %0d busy %b want 1 0 1", clear, shadow, busy); end
        req = 4'b0000; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (clear !== 1'b0) begin n_bad++; $display("FAIL midrst_clear_single got %b want 0", clear); end
        wait_idle(cyc);
        n_cmp++; if (cyc !== 3 || mismatch !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL midrst_end cyc %0d mismatch %b count %0d want 3 0 0", cyc, mismatch, count); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_round_robin();
        test_clear_priority();
        test_fault();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
